// File: rtl/matrix_pipeline_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pipeline_mac_pkg
//  Description : Shared widths and FSM state type for the 3x3 matrix MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_pipeline_mac_pkg;

    localparam int DATA_W = 8;   // operand width
    localparam int PROD_W = 16;  // 8x8 product width
    localparam int ACC_W  = 18;  // accumulator width (three products)
    localparam int OUT_W  = 16;  // result width, modulo 2^16
    localparam int N      = 3;   // matrix dimension

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_pipeline_mac_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pipeline_mac_if
//  Description : Operand/result bus between the matrix front-end and the MAC.
//                master : front-end (drives start, a*, b*; reads c*, done)
//                slave  : matrix_pipeline_mac_top
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_pipeline_mac_if;
    import matrix_pipeline_mac_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
    logic [DATA_W-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic [OUT_W-1:0]  c11, c12, c13, c21, c22, c23, c31, c32, c33;
    logic              done;

    modport master (
        output start,
        output a11, a12, a13, a21, a22, a23, a31, a32, a33,
        output b11, b12, b13, b21, b22, b23, b31, b32, b33,
        input  c11, c12, c13, c21, c22, c23, c31, c32, c33,
        input  done
    );

    modport slave (
        input  start,
        input  a11, a12, a13, a21, a22, a23, a31, a32, a33,
        input  b11, b12, b13, b21, b22, b23, b31, b32, b33,
        output c11, c12, c13, c21, c22, c23, c31, c32, c33,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/mac_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lane
//  Description : One multiply-accumulate lane: 8x8 multiplier, registered
//                16-bit product and 18-bit accumulator.
//  Ports       : clk, rst    - clock, asynchronous active-high reset
//                clr         - zero the accumulator
//                load_p      - register a*b into the product stage
//                acc_en      - add the registered product to the accumulator
//                a, b        - operands for the current k-step
//                acc_lo      - low OUT_W bits of the accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_lane
    import matrix_pipeline_mac_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clr,
    input  wire logic              load_p,
    input  wire logic              acc_en,
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    output logic      [OUT_W-1:0]  acc_lo
);

    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] r_p;
    logic [ACC_W-1:0]  r_acc;

    assign w_prod = {{(PROD_W-DATA_W){1'b0}}, a} * {{(PROD_W-DATA_W){1'b0}}, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p   <= '0;
            r_acc <= '0;
        end else begin
            if (clr) begin
                r_acc <= '0;
            end else if (acc_en) begin
                r_acc <= r_acc + {{(ACC_W-PROD_W){1'b0}}, r_p};
            end
            if (load_p) begin
                r_p <= w_prod;
            end
        end
    end

    assign acc_lo = r_acc[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/matrix_pipeline_mac_top.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pipeline_mac_top
//  Description : Pipelined 3x3 unsigned matrix multiplier C = A*B using nine
//                MAC lanes stepped over k = 0..2. Fixed 5-clock latency from
//                the start-sampling edge to the one-cycle done pulse.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - slave side of matrix_pipeline_mac_if
//                       (start, a11..a33, b11..b33 in; c11..c33, done out)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_pipeline_mac_top
    import matrix_pipeline_mac_pkg::*;
(
    input wire logic             clk,
    input wire logic             rst,
    matrix_pipeline_mac_if.slave bus
);

    state_t            r_state;
    logic [1:0]        r_k;
    logic              r_done;
    logic [DATA_W-1:0] r_a [N][N];
    logic [DATA_W-1:0] r_b [N][N];
    logic [OUT_W-1:0]  r_c [N][N];

    logic [DATA_W-1:0] w_a_op [N];   // column k of A, one entry per row i
    logic [DATA_W-1:0] w_b_op [N];   // row k of B, one entry per column j
    logic [OUT_W-1:0]  w_acc_lo [N][N];
    logic              w_clr;
    logic              w_load_p;
    logic              w_acc_en;

    // Lane controls decode directly from the current state so each lane acts
    // on the same edge that the FSM leaves that state.
    assign w_clr    = (r_state == IDLE) && bus.start;
    assign w_load_p = (r_state == LOAD) || (r_state == MAC);
    assign w_acc_en = (r_state == MAC)  || (r_state == DRAIN);

    // Operand selection for the current k-step.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_op[i] = r_a[i][0];
            w_b_op[i] = r_b[0][i];
            case (r_k)
                2'd1: begin
                    w_a_op[i] = r_a[i][1];
                    w_b_op[i] = r_b[1][i];
                end
                2'd2: begin
                    w_a_op[i] = r_a[i][2];
                    w_b_op[i] = r_b[2][i];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= 2'd0;
            r_done  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_a[i][j] <= '0;
                    r_b[i][j] <= '0;
                    r_c[i][j] <= '0;
                end
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a[0][0] <= bus.a11; r_a[0][1] <= bus.a12; r_a[0][2] <= bus.a13;
                        r_a[1][0] <= bus.a21; r_a[1][1] <= bus.a22; r_a[1][2] <= bus.a23;
                        r_a[2][0] <= bus.a31; r_a[2][1] <= bus.a32; r_a[2][2] <= bus.a33;
                        r_b[0][0] <= bus.b11; r_b[0][1] <= bus.b12; r_b[0][2] <= bus.b13;
                        r_b[1][0] <= bus.b21; r_b[1][1] <= bus.b22; r_b[1][2] <= bus.b23;
                        r_b[2][0] <= bus.b31; r_b[2][1] <= bus.b32; r_b[2][2] <= bus.b33;
                        r_k     <= 2'd0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_k     <= 2'd1;
                    r_state <= MAC;
                end
                MAC: begin
                    // k=2 is the last product issued; its sum lands in DRAIN.
                    if (r_k == 2'd2) begin
                        r_k     <= 2'd0;
                        r_state <= DRAIN;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                end
                DONE: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            r_c[i][j] <= w_acc_lo[i][j];
                        end
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_lane u_lane (
                .clk    (clk),
                .rst    (rst),
                .clr    (w_clr),
                .load_p (w_load_p),
                .acc_en (w_acc_en),
                .a      (w_a_op[gi]),
                .b      (w_b_op[gj]),
                .acc_lo (w_acc_lo[gi][gj])
            );
        end
    end

    assign bus.c11  = r_c[0][0];
    assign bus.c12  = r_c[0][1];
    assign bus.c13  = r_c[0][2];
    assign bus.c21  = r_c[1][0];
    assign bus.c22  = r_c[1][1];
    assign bus.c23  = r_c[1][2];
    assign bus.c31  = r_c[2][0];
    assign bus.c32  = r_c[2][1];
    assign bus.c33  = r_c[2][2];
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_pipeline_mac_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_pipeline_mac_top
//  Description : Self-checking bench for matrix_pipeline_mac_top. A driver
//                issues operations and queues the expected result and done
//                cycle; a monitor compares whenever done is seen and checks
//                that c* hold between results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_pipeline_mac_top;
    import matrix_pipeline_mac_pkg::*;

    typedef logic [8:0][7:0]  mat_t;   // element [i*3+j], row-major
    typedef logic [8:0][15:0] res_t;
    typedef struct packed {
        int unsigned cyc;
        res_t        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    res_t        last_c = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_pipeline_mac_if bus ();

    matrix_pipeline_mac_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain matrix product, each entry reduced modulo 2^16.
    function automatic res_t model(input mat_t a, input mat_t b);
        res_t r;
        int   sum;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum = 0;
                for (int k = 0; k < 3; k++) begin
                    sum += int'(a[i*3+k]) * int'(b[k*3+j]);
                end
                r[i*3+j] = 16'(sum % 65536);
            end
        end
        return r;
    endfunction

    function automatic res_t get_c();
        return {bus.c33, bus.c32, bus.c31, bus.c23, bus.c22, bus.c21,
                bus.c13, bus.c12, bus.c11};
    endfunction

    task automatic set_ab(input mat_t a, input mat_t b);
        bus.a11 = a[0]; bus.a12 = a[1]; bus.a13 = a[2];
        bus.a21 = a[3]; bus.a22 = a[4]; bus.a23 = a[5];
        bus.a31 = a[6]; bus.a32 = a[7]; bus.a33 = a[8];
        bus.b11 = b[0]; bus.b12 = b[1]; bus.b13 = b[2];
        bus.b21 = b[3]; bus.b22 = b[4]; bus.b23 = b[5];
        bus.b31 = b[6]; bus.b32 = b[7]; bus.b33 = b[8];
    endtask

    // Presents operands with start; returns 1 time unit after the sampling
    // edge E0. The result must appear after E0+5.
    task automatic issue(input mat_t a, input mat_t b);
        exp_t e;
        set_ab(a, b);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.cyc = cyc + 5;
        e.c   = model(a, b);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (get_c() !== '0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s: c=%h done=%b, required c=0 done=0", name, get_c(), bus.done);
        end
    endtask

    // Monitor: compares on every done, otherwise checks c* are held.
    always @(negedge clk) begin
        if (rst) begin
            last_c = '0;
        end else if (bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (get_c() !== mon_e.c) begin
                    errors++;
                    $display("FAIL result: c=%h required %h", get_c(), mon_e.c);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d required %0d", cyc, mon_e.cyc);
                end
            end
            last_c = get_c();
        end else begin
            checks++;
            if (get_c() !== last_c) begin
                errors++;
                $display("FAIL hold: c=%h changed without done, required %h", get_c(), last_c);
            end
        end
    end

    initial begin
        mat_t a, b, a2, b2;

        rst = 1'b1;
        bus.start = 1'b0;
        set_ab('0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity times 1..9.
        a = '0; a[0] = 8'd1; a[4] = 8'd1; a[8] = 8'd1;
        for (int i = 0; i < 9; i++) b[i] = 8'(i + 1);
        issue(a, b);
        wait_idle();

        // [1..9] times [9..1].
        for (int i = 0; i < 9; i++) begin
            a[i] = 8'(i + 1);
            b[i] = 8'(9 - i);
        end
        issue(a, b);
        wait_idle();

        // All-255 operands wrap modulo 2^16.
        a = {9{8'hFF}};
        b = {9{8'hFF}};
        issue(a, b);
        wait_idle();

        // Input isolation plus starts while busy (at E2 and in the DONE cycle).
        for (int i = 0; i < 9; i++) begin
            a[i] = 8'($urandom_range(1, 255));
            b[i] = 8'($urandom_range(1, 255));
        end
        issue(a, b);
        set_ab('0, '0);
        @(posedge clk);       // E1
        #1;
        bus.start = 1'b1;
        @(posedge clk);       // E2 samples start while busy
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);       // E5: DONE cycle, start must be ignored
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        #1;

        // Reset mid-operation at E3.
        for (int i = 0; i < 9; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'($urandom_range(0, 255));
        end
        issue(a, b);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_zero("reset_midop");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        issue(a, b);
        wait_idle();

        // Back-to-back: second start sampled at E6, done at E5 and E11.
        for (int i = 0; i < 9; i++) begin
            a[i]  = 8'($urandom_range(0, 255));
            b[i]  = 8'($urandom_range(0, 255));
            a2[i] = 8'($urandom_range(0, 255));
            b2[i] = 8'($urandom_range(0, 255));
        end
        issue(a, b);
        repeat (5) @(posedge clk);
        #1;
        issue(a2, b2);
        wait_idle();

        // Randomized stream with minimum or slightly larger spacing.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 9; i++) begin
                a[i] = 8'($urandom);
                b[i] = 8'($urandom);
            end
            issue(a, b);
            repeat (5) @(posedge clk);
            #1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
